// File: rtl/mul_div_if.sv
`default_nettype none
// ============================================================================
// Module  : mul_div_if
// Brief   : Request/response bundle between the EX-stage control logic and
//           the iterative multiply/divide unit.
// Revision: 1.0  initial release
// ============================================================================
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               div_by_zero;

  // Pipeline control side: issues requests, watches busy/done.
  modport master (
    output start, op, a, b,
    input  busy, done, result, div_by_zero
  );

  // Execution unit side.
  modport slave (
    input  start, op, a, b,
    output busy, done, result, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : mul_div_unit
// Brief   : Iterative multu/mult/divu/div unit. Shift-add multiply and
//           restoring divide on operand magnitudes, one bit per clock, with
//           a single sign-fix cycle. Result is {HI,LO}.
// Revision: 1.0  initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mul_div_if.slave    bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;

  // op[1] selects divide, op[0] selects signed.
  logic               r_is_div;
  logic               r_neg_r;
  logic               r_neg_rem;
  logic               r_b_zero;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_opnd;   // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   r_hi;     // product high half / partial remainder
  logic [WIDTH-1:0]   r_lo;     // multiplier bits / dividend-then-quotient
  logic [2*WIDTH-1:0] r_result;
  logic               r_done;
  logic               r_dbz;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH+1:0]   w_div_diff;
  logic               w_div_ok;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_fix_result;

  // Magnitudes of the incoming operands; 2^(WIDTH-1) stays representable unsigned.
  assign w_a_mag = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_mag = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // One multiply step: add multiplicand when the current multiplier LSB is set.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

  // One restoring-divide step: shift in next dividend bit, trial-subtract.
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};
  assign w_div_ok    = ~w_div_diff[WIDTH+1];

  // Sign correction. With a zero divisor the remainder is the dividend
  // magnitude, so re-applying the dividend sign reproduces the raw A exactly.
  assign w_prod       = {r_hi, r_lo};
  assign w_quo        = r_b_zero ? {WIDTH{1'b1}} : (r_neg_r ? -r_lo : r_lo);
  assign w_rem        = r_neg_rem ? -r_hi : r_hi;
  assign w_fix_result = r_is_div ? {w_rem, w_quo} : (r_neg_r ? -w_prod : w_prod);

  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.div_by_zero = r_dbz;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: accept only in IDLE, WIDTH iterations, one fix cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (r_cnt == LAST_ITER) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_div  <= 1'b0;
      r_neg_r   <= 1'b0;
      r_neg_rem <= 1'b0;
      r_b_zero  <= 1'b0;
      r_cnt     <= '0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (r_state == IDLE && bus.start) begin
      r_is_div  <= bus.op[1];
      r_neg_r   <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      r_neg_rem <= bus.op[0] & bus.op[1] & bus.a[WIDTH-1];
      r_b_zero  <= bus.op[1] & (bus.b == '0);
      r_cnt     <= '0;
      r_hi      <= '0;
      r_opnd    <= bus.op[1] ? w_b_mag : w_a_mag;
      r_lo      <= bus.op[1] ? w_a_mag : w_b_mag;
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_is_div) begin
        r_hi <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], w_div_ok};
      end else begin
        r_hi <= w_mul_sum[WIDTH:1];
        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  // Output registers: result updates only at the end of FIX, done/dbz pulse once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (r_state == FIX) begin
      r_result <= w_fix_result;
      r_done   <= 1'b1;
      r_dbz    <= r_b_zero;
    end else begin
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul_div_unit
// Brief   : Scoreboard bench for mul_div_unit with directed vectors.
// Revision: 1.0  initial release
// ============================================================================
module tb_mul_div_unit;

  localparam int WIDTH = 32;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   failures = 0;
  logic [63:0] hold = 64'd0;
  exp_t sb[$];

  mul_div_if #(.WIDTH(WIDTH)) bus ();

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every Done against the oldest expected response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", bus.result, e.res);
          chk("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("busy_at_done", {63'd0, bus.busy}, 64'd0);
          hold = e.res;
        end
      end else begin
        chk("result_hold", bus.result, hold);
        chk("dbz_idle", {63'd0, bus.div_by_zero}, 64'd0);
      end
    end
  end

  // Caller must be at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input logic dbz);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    e.res = res;
    e.dbz = dbz;
    e.cyc = cyc + WIDTH + 1;
    sb.push_back(e);
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_waiting_done", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("timeout_done", 64'd0, 64'd1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    chk("reset_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    chk("reset_result", bus.result, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-computed {HI,LO}.
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
    wait_idle(60);
    issue(2'b01, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 1'b0);
    wait_idle(60);
    issue(2'b01, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
    wait_idle(60);
    issue(2'b01, 32'h00000007, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFF9, 1'b0);
    wait_idle(60);
    issue(2'b11, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    wait_idle(60);
    issue(2'b11, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
    wait_idle(60);
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    wait_idle(60);
    issue(2'b10, 32'd100, 32'd0, 64'h00000064_FFFFFFFF, 1'b1);
    wait_idle(60);
    issue(2'b11, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 1'b1);
    wait_idle(60);
    issue(2'b10, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
    wait_idle(60);

    // Start during RUN must be ignored.
    issue(2'b00, 32'h12345678, 32'h00000010, 64'h00000001_23456780, 1'b0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'hFFFFFFFF;
    bus.b     = 32'h00000002;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(60);
    repeat (WIDTH + 4) @(negedge clk);

    // Back-to-back: second Start in the Done cycle of the first.
    issue(2'b00, 32'd3, 32'd4, 64'h00000000_0000000C, 1'b0);
    wait_done(60);
    issue(2'b10, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
    wait_idle(60);

    // Asynchronous reset mid-divide aborts the operation.
    issue(2'b11, 32'd1000, 32'd3, 64'h00000001_0000014D, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    chk("abort_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    chk("abort_result", bus.result, 64'd0);
    sb.delete();
    hold = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 5) @(negedge clk);
    issue(2'b00, 32'd6, 32'd7, 64'h00000000_0000002A, 1'b0);
    wait_idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the EX stage.
- Produces the 64-bit {HI,LO} result that feeds the 64-bit 2:1 writeback-select mux, which chooses between the ALU path and the HI/LO path.
- Supports unsigned and signed multiply and divide using MIPS mult/multu/div/divu semantics.
- Control logic stalls the pipeline while Busy is high.

Parameters:
- WIDTH, 32, operand width; Result width is 2*WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- Start  input  1  request; accepted only in IDLE.
- Op  input  2  operation: 00 multu, 01 mult, 10 divu, 11 div; sampled with Start.
- A  input  WIDTH  multiplicand or dividend; sampled with Start.
- B  input  WIDTH  multiplier or divisor; sampled with Start.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when Result updates.
- Result  output  2*WIDTH  {HI,LO}. Multiply: full product. Divide: HI=remainder, LO=quotient.
- DivByZero  output  1  pulses with Done when a divide had B==0.

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE; Busy=0, Done=0, DivByZero=0, Result=0; all internal registers cleared. Reset asserted mid-operation aborts the operation; no Done is produced.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - If Start=1 at a rising edge: latch Op, A, B and go to RUN. Busy=1 from the next cycle.
  - For signed ops, latch operand magnitudes plus the sign flags negR and negRem:
    - negR = sign(A) XOR sign(B).
    - negRem = sign(A), used for divide only.
  - Clear the iteration counter.
- RUN: one iteration per clock, exactly WIDTH cycles.
  - Multiply: shift-add on a 2*WIDTH accumulator. One multiplier bit per cycle, LSB first.
  - Divide: restoring division. Shift the remainder left by 1 and bring in the next dividend bit, MSB first. Then trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
  - After the WIDTH-th iteration, go to FIX.
- FIX: one cycle, then IDLE.
  - Apply sign correction using two's-complement negation.
  - Signed multiply: negate the 2*WIDTH product if negR.
  - Signed divide: negate the quotient if negR; negate the remainder if negRem.
  - Write Result. In the following cycle Done=1 and Busy=0.
- Latency: Start accepted at edge k → Result valid and Done=1 in the cycle after edge k+WIDTH+1.
  - Busy is high for WIDTH+1 cycles.
  - Done is high for exactly 1 cycle.
- Start while Busy=1: ignored. It is not queued and operands are not resampled.
- Start in the same cycle as Done: accepted (state is IDLE). Done still pulses once for the prior operation.
- Result holds its value until the next FIX; it does not change during RUN.
- Divide by zero (B==0, divu or div):
  - Result = {A, all-ones}, i.e. remainder = raw A, quotient = 0xFFFFFFFF.
  - No sign correction is applied.
  - DivByZero=1 together with Done.
  - Latency is unchanged (full WIDTH+1).
- Signed overflow (div, A=-2^(WIDTH-1), B=-1): quotient = 0x80000000 and remainder = 0. This falls out naturally from magnitude division plus negation mod 2^WIDTH; the implementation must not special-case it.
- Most-negative operands in mult: the magnitude of 0x80000000 is treated as an unsigned 2^31. Product widths never truncate.
- No other errors or exceptions. DivByZero is 0 for all multiplies.

Test Plan:
- multu, A=0xFFFFFFFF, B=0xFFFFFFFF → exactly WIDTH+1 cycles after Start: Done=1, Result=0xFFFFFFFE_00000001, DivByZero=0, Busy falls with Done.
- mult, A=0xFFFFFFFD (-3), B=5 → Result=0xFFFFFFFF_FFFFFFF1.
- mult, A=0x80000000, B=0x80000000 → Result=0x40000000_00000000.
- div, A=0xFFFFFFF9 (-7), B=2 → Result={0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quo -3).
- div, A=0x80000000, B=0xFFFFFFFF → Result={0x00000000, 0x80000000}.
- divu, A=100, B=0 → Result={0x00000064, 0xFFFFFFFF}, DivByZero=1 for one cycle.
- divu, A=100, B=7 → Result={0x00000002, 0x0000000E}.
- Start pulsed at cycle 5 of a running multu with different A/B → ignored; original product delivered; exactly one Done.
- Back-to-back: Start asserted in the Done cycle → second op accepted, second Done exactly WIDTH+1 cycles later.
- Rst driven low at cycle 10 of a div → Busy, Done, DivByZero and Result go to 0 immediately without a clock edge. After release, no Done appears; a fresh multu 6×7 yields 0x00000000_0000002A.
